// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch-side instruction memory: default widths,
// FSM state encoding and the log2 helper used to derive address offsets.
package pipeline_pkg;

  localparam int NB_WIDTH_DEF = 32;
  localparam int PC_WIDTH_DEF = 11;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  typedef enum logic [1:0] {
    S_CLEAR = ST_CLEAR,
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD
  } state_e;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects loader bytes big-endian into a word. Emits a one-cycle write strobe
// when a word completes (the completing byte is included combinationally) or
// when a flush arrives with a partial word, which is then zero-padded low.
module byte_word_assembler
  import pipeline_pkg::*;
#(
  parameter int NB_WIDTH = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                discard_i,
  input  logic                valid_i,
  input  logic [NB_BYTE-1:0]  byte_i,
  input  logic                flush_i,
  output logic                wr_en_o,
  output logic [NB_WIDTH-1:0] wr_word_o
);

  localparam int BYTES = NB_WIDTH / NB_BYTE;
  localparam int CW    = (log2(BYTES) > 0) ? log2(BYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BYTES - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NB_WIDTH-1:0] shift_q, shift_d;
  logic [NB_WIDTH-1:0] assembled_s;

  // Merge the incoming byte into its big-endian slot and decide the next state.
  always_comb begin
    assembled_s = shift_q;
    for (int i = 0; i < BYTES; i++) begin
      if (cnt_q == CW'(i)) begin
        assembled_s[NB_WIDTH-1-NB_BYTE*i -: NB_BYTE] = byte_i;
      end else begin
        assembled_s = assembled_s;
      end
    end

    cnt_d     = cnt_q;
    shift_d   = shift_q;
    wr_en_o   = 1'b0;
    wr_word_o = assembled_s;

    if (discard_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (valid_i) begin
      if ((cnt_q == CNT_LAST) || flush_i) begin
        wr_en_o = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        shift_d = assembled_s;
      end
    end else if (flush_i && (cnt_q != '0)) begin
      wr_en_o   = 1'b1;
      wr_word_o = shift_q;
      cnt_d     = '0;
      shift_d   = '0;
    end else begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
    end
  end

  // Byte counter and partial-word register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: byte-serial loader, registered byte-addressed
// fetch, and a one-word-per-cycle hardware sweep for clearing.
module instruction_memory_loadable
  import pipeline_pkg::*;
#(
  parameter int NB_WIDTH = NB_WIDTH_DEF,
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int NB_BYTE  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_clear,
  input  logic                      i_read_enable,
  input  logic [PC_WIDTH-1:0]       i_pc,
  output logic [NB_WIDTH-1:0]       o_instruction,
  output logic                      o_misaligned,
  input  logic                      i_load_start,
  input  logic                      i_load_valid,
  input  logic [NB_BYTE-1:0]        i_load_byte,
  input  logic                      i_load_done,
  output logic [PC_WIDTH-log2(NB_WIDTH/8):0] o_load_count,
  output logic                      o_load_full,
  output logic                      o_ready,
  output logic                      o_busy
);

  localparam int BYTES = NB_WIDTH / 8;
  localparam int OFS   = log2(BYTES);
  localparam int AW    = PC_WIDTH - OFS;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   PTR_LAST = (AW+1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic [AW:0]         ptr_q, ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                full_q, full_d;
  logic [NB_WIDTH-1:0] instr_q, instr_d;
  logic                mis_q, mis_d;

  logic [NB_WIDTH-1:0] mem_q [DEPTH];
  logic                mem_we_s;
  logic [AW-1:0]       mem_waddr_s;
  logic [NB_WIDTH-1:0] mem_wdata_s;
  logic [NB_WIDTH-1:0] rd_data_s;

  logic                asm_discard_s;
  logic                asm_valid_s;
  logic                asm_flush_s;
  logic                asm_wr_s;
  logic [NB_WIDTH-1:0] asm_word_s;

  assign rd_data_s = mem_q[i_pc[PC_WIDTH-1:OFS]];

  // Loader byte path: only live in LOAD, gated off by abort/restart and when full.
  assign asm_discard_s = (state_q != S_LOAD) || i_clear || i_load_start;
  assign asm_valid_s   = i_load_valid && !full_q;
  assign asm_flush_s   = i_load_done;

  byte_word_assembler #(
    .NB_WIDTH (NB_WIDTH),
    .NB_BYTE  (NB_BYTE)
  ) u_asm (
    .clk_i     (i_clk),
    .rst_i     (i_reset),
    .discard_i (asm_discard_s),
    .valid_i   (asm_valid_s),
    .byte_i    (i_load_byte),
    .flush_i   (asm_flush_s),
    .wr_en_o   (asm_wr_s),
    .wr_word_o (asm_word_s)
  );

  // Next-state, write-port and fetch-output logic.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    full_d      = full_q;
    instr_d     = instr_q;
    mis_d       = mis_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = ptr_q[AW-1:0];
    mem_wdata_s = asm_word_s;

    case (state_q)
      S_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_cnt_q;
        mem_wdata_s = '0;
        instr_d     = '0;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      S_IDLE: begin
        if (i_clear) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
          count_d   = '0;
          full_d    = 1'b0;
          instr_d   = '0;
        end else if (i_load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          count_d = '0;
          full_d  = 1'b0;
        end else if (i_read_enable) begin
          instr_d = rd_data_s;
          mis_d   = |i_pc[OFS-1:0];
        end else begin
          instr_d = instr_q;
        end
      end
      S_LOAD: begin
        if (i_clear) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
          count_d   = '0;
          full_d    = 1'b0;
          instr_d   = '0;
        end else if (i_load_start) begin
          ptr_d   = '0;
          count_d = '0;
          full_d  = 1'b0;
        end else begin
          if (asm_wr_s) begin
            mem_we_s = 1'b1;
            ptr_d    = ptr_q + (AW+1)'(1);
            count_d  = count_q + (AW+1)'(1);
            full_d   = (ptr_q == PTR_LAST);
          end else begin
            mem_we_s = 1'b0;
          end
          if (i_load_done) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Control and output registers; any reset restarts the full clear sweep.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      instr_q   <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      instr_q   <= instr_d;
      mis_q     <= mis_d;
    end
  end

  // Single write port; contents are defined by the clear sweep, not by reset.
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign o_instruction = instr_q;
  assign o_misaligned  = mis_q;
  assign o_load_count  = count_q;
  assign o_load_full   = full_q;
  assign o_ready       = (state_q == S_IDLE);
  assign o_busy        = (state_q == S_CLEAR);

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench with a fetch scoreboard and an independent memory model.
module tb_instruction_memory_loadable;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        re = 1'b0;
  logic [10:0] pc = 11'd0;
  logic [31:0] instr;
  logic        mis;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'd0;
  logic        ld_done = 1'b0;
  logic [9:0]  ld_count;
  logic        ld_full;
  logic        ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic        mis;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_word;
  int          m_n;
  int          m_ptr;
  logic [7:0]  byte_q[$];

  instruction_memory_loadable dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_clear       (clr),
    .i_read_enable (re),
    .i_pc          (pc),
    .o_instruction (instr),
    .o_misaligned  (mis),
    .i_load_start  (ld_start),
    .i_load_valid  (ld_valid),
    .i_load_byte   (ld_byte),
    .i_load_done   (ld_done),
    .o_load_count  (ld_count),
    .o_load_full   (ld_full),
    .o_ready       (ready),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_word = 32'h0;
    m_n = 0;
    m_ptr = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_ptr < DEPTH) begin
      m_word = {m_word[23:0], b};
      m_n++;
      if (m_n == 4) begin
        m_mem[m_ptr] = m_word;
        m_ptr++;
        m_n = 0;
        m_word = 32'h0;
      end
    end
  endtask

  task automatic model_flush();
    if (m_n != 0) begin
      m_mem[m_ptr] = m_word << (8 * (4 - m_n));
      m_ptr++;
      m_n = 0;
      m_word = 32'h0;
    end
  endtask

  // Called at a negedge; returns at a negedge with the load finished.
  task automatic load_bytes(input logic done_with_last);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    m_ptr = 0; m_n = 0; m_word = 32'h0;
    for (int i = 0; i < byte_q.size(); i++) begin
      ld_valid = 1'b1;
      ld_byte = byte_q[i];
      model_byte(byte_q[i]);
      if (done_with_last && (i == byte_q.size() - 1)) ld_done = 1'b1;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    if (!done_with_last) begin
      ld_done = 1'b1;
      @(negedge clk);
    end
    ld_done = 1'b0;
    model_flush();
  endtask

  task automatic fetch(input string tag, input logic [10:0] p);
    exp_t e;
    exp_t got;
    re = 1'b1;
    pc = p;
    e.instr = m_mem[p[10:2]];
    e.mis = |p[1:0];
    sb_q.push_back(e);
    @(negedge clk);
    re = 1'b0;
    got = sb_q.pop_front();
    check({tag, "_instr"}, {32'h0, instr}, {32'h0, got.instr});
    check({tag, "_mis"}, {63'h0, mis}, {63'h0, got.mis});
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while ((busy === 1'b1) && (n < 2 * DEPTH)) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(DEPTH));
    check({tag, "_ready"}, {63'h0, ready}, 64'h1);
  endtask

  initial begin
    model_clear();
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_instr", {32'h0, instr}, 64'h0);
    check("rst_mis", {63'h0, mis}, 64'h0);
    check("rst_count", {54'h0, ld_count}, 64'h0);
    check("rst_full", {63'h0, ld_full}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h1);
    check("rst_ready", {63'h0, ready}, 64'h0);
    rst = 1'b0;
    count_busy("init");
    fetch("clear_1fc", 11'h1FC);
    check("clear_1fc_const", {32'h0, instr}, 64'h0);

    // Two full words
    byte_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
    load_bytes(1'b0);
    check("ld2_count", {54'h0, ld_count}, 64'd2);
    check("ld2_ready", {63'h0, ready}, 64'h1);
    fetch("ld2_pc0", 11'h000);
    check("ld2_pc0_const", {32'h0, instr}, 64'h8C010004);
    fetch("ld2_pc4", 11'h004);
    check("ld2_pc4_const", {32'h0, instr}, 64'h20020005);

    // Partial word flushed zero-padded
    byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    load_bytes(1'b0);
    check("part_count", {54'h0, ld_count}, 64'd2);
    fetch("part_pc4", 11'h004);
    check("part_pc4_const", {32'h0, instr}, 64'h11220000);
    fetch("part_pc0", 11'h000);

    // Misaligned fetch and hold
    fetch("mis_pc6", 11'h006);
    check("mis_pc6_const", {31'h0, mis, instr}, {31'h0, 1'b1, 32'h11220000});
    pc = 11'h000;
    @(negedge clk);
    check("hold_instr", {32'h0, instr}, 64'h11220000);
    check("hold_mis", {63'h0, mis}, 64'h1);
    fetch("align_pc0", 11'h000);

    // Byte and done in the same cycle: byte taken, then partial flushed
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    load_bytes(1'b1);
    check("vd_count", {54'h0, ld_count}, 64'd2);
    fetch("vd_pc4", 11'h004);
    check("vd_pc4_const", {32'h0, instr}, 64'h05000000);
    fetch("vd_pc0", 11'h000);

    // Overfill: DEPTH words plus one extra word
    byte_q = {};
    for (int k = 0; k < DEPTH * 4 + 4; k++) byte_q.push_back(8'((k * 7 + 3) & 255));
    load_bytes(1'b0);
    check("full_flag", {63'h0, ld_full}, 64'h1);
    check("full_count", {54'h0, ld_count}, 64'd512);
    fetch("full_first", 11'h000);
    check("full_first_const", {32'h0, instr}, 64'h030A1118);
    fetch("full_last", 11'h7FC);
    fetch("full_mid", 11'h401);

    // Clear aborts a load after two bytes
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_byte = 8'hEE;
    @(negedge clk);
    ld_byte = 8'hFF;
    @(negedge clk);
    ld_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check("abort_instr", {32'h0, instr}, 64'h0);
    check("abort_count", {54'h0, ld_count}, 64'h0);
    check("abort_full", {63'h0, ld_full}, 64'h0);
    count_busy("abort");
    fetch("abort_pc0", 11'h000);
    fetch("abort_pc7fc", 11'h7FC);
    fetch("abort_pc200", 11'h200);

    // Reset during a clear sweep restarts the full count
    byte_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    load_bytes(1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {63'h0, busy}, 64'h1);
    rst = 1'b0;
    count_busy("rst_mid");
    fetch("rst_mid_pc0", 11'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loadable.md
Name: instruction_memory_loadable

Overview:
Parametrised instruction memory for the pipeline fetch stage. Program words are written by a byte-serial loader port, driven by the debug/UART unit. Fetch reads are synchronous and byte-addressed by the PC. Clearing is done by a hardware sweep, not a single-cycle wipe, so depth can grow without a huge reset fan-out. Sits between the debug unit (loader side) and the IF stage (fetch side).

Parameters:
NB_WIDTH, 32, instruction word width in bits; multiple of 8.
PC_WIDTH, 11, byte-address width of the PC.
NB_BYTE, 8, loader byte width (fixed 8, exposed for consistency).
Derived localparams: BYTES = NB_WIDTH/8; OFS = log2(BYTES); AW = PC_WIDTH-OFS; DEPTH = 2**AW words.

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_clear  in  1  synchronous request to sweep-clear the memory
i_read_enable  in  1  fetch enable
i_pc  in  PC_WIDTH  fetch byte address
o_instruction  out  NB_WIDTH  fetched word, registered
o_misaligned  out  1  registered: last fetch had i_pc[OFS-1:0] != 0
i_load_start  in  1  enter LOAD; write pointer and byte counter set to 0
i_load_valid  in  1  i_load_byte is valid this cycle
i_load_byte  in  NB_BYTE  program byte
i_load_done  in  1  end of load; flush any partial word
o_load_count  out  AW+1  words written since last i_load_start
o_load_full  out  1  write pointer reached DEPTH
o_ready  out  1  state == IDLE
o_busy  out  1  state == CLEAR

Behaviour:
- FSM states: CLEAR, IDLE, LOAD. Asynchronous reset forces CLEAR with:
  - clear counter 0, o_instruction 0, o_misaligned 0, o_load_count 0, o_load_full 0, byte counter 0, byte shift register 0.
- CLEAR:
  - Writes 0 to word[clear_cnt] each cycle, clear_cnt++.
  - After writing DEPTH-1, goes to IDLE. CLEAR lasts exactly DEPTH cycles after reset release (or after i_clear is sampled).
  - o_instruction is held at 0 throughout.
  - i_load_*, i_read_enable and i_clear are ignored.
- IDLE:
  - If i_read_enable, then next edge: o_instruction = mem[i_pc[PC_WIDTH-1:OFS]] and o_misaligned = |i_pc[OFS-1:0]. Latency is 1 cycle.
  - Low bits are ignored for addressing. The upper index field wraps naturally.
  - If !i_read_enable, o_instruction and o_misaligned hold.
  - Priority: i_clear > i_load_start > fetch.
  - i_clear goes to CLEAR and also zeroes o_load_count and o_load_full.
  - i_load_start goes to LOAD, pointer=0, o_load_count=0, o_load_full=0.
- LOAD:
  - Fetch is disabled and o_instruction holds.
  - Each i_load_valid shifts the byte in big-endian order: first byte lands in bits [NB_WIDTH-1:NB_WIDTH-8].
  - On the BYTES-th byte:
    - Word written to mem[pointer] in that same cycle, including the incoming byte.
    - pointer++, o_load_count++, byte counter reset.
  - When pointer == DEPTH, o_load_full=1 and further bytes are dropped with no wrap or overwrite.
  - i_load_done:
    - If byte counter != 0, the partial word is written zero-padded in the low bytes, counted, and pointer++ (unless full).
    - Then goes to IDLE.
    - If i_load_valid and i_load_done arrive together, the byte is accepted first, then the flush applies.
  - i_clear during LOAD aborts: goes to CLEAR, partial bytes discarded.
  - i_load_start during LOAD restarts the pointer at 0. Memory contents are not cleared.
- Memory is inferred as a single-write-port, single-read-port array. No read-during-write hazard is possible, since fetch and load are mutually exclusive.
- Reset mid-CLEAR or mid-LOAD restarts the full CLEAR.

Decomposition:
- Shared package pipeline_pkg holds:
  - NB_WIDTH and PC_WIDTH defaults.
  - The 2-bit state encoding localparams ST_CLEAR=0, ST_IDLE=1, ST_LOAD=2.
  - The log2 function used for OFS.
- One natural sub-module: byte_word_assembler, containing the shift register, byte counter, word-ready pulse and zero-padded flush.
- The memory array and FSM stay in the top module.

Test Plan:
- Reset, then hold i_reset low for DEPTH cycles -> o_busy=1 for exactly DEPTH cycles, then o_ready=1; fetch pc=0x1FC -> 0x00000000.
- Load start, bytes 8C,01,00,04, 20,02,00,05, then done -> o_load_count=2; fetch pc=0 -> 0x8C010004 next cycle; pc=4 -> 0x20020005.
- Load 6 bytes AA,BB,CC,DD,11,22, then done -> word1 = 0x11220000, o_load_count=2.
- Fetch pc=6 -> o_instruction=mem[1], o_misaligned=1; drop i_read_enable and change pc -> output holds.
- Load DEPTH*4+4 bytes -> o_load_full=1 after DEPTH words; last word = the DEPTH-th word; mem[0] not overwritten.
- i_clear mid-load after 2 bytes -> DEPTH-cycle CLEAR; all fetches return 0; async i_reset mid-CLEAR restarts the count.
